// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined fixed-point adder with valid/ready on both sides.
// Operands in Q(i1,f1) and Q(i2,f2), each signed or unsigned; result in Q(i3,f3).
// Stage 1 aligns both operands into a common signed internal format, stage 2 adds
// exactly, stage 3 truncates to the output fraction and range-checks.
// Build option: define FP_ADD_SAT_EN to saturate out-of-range results to the
// format limits; otherwise the low i3+f3 bits are kept (wrap-around).
module fp_add_pipe #(
  parameter int unsigned i1 = 2,
  parameter int unsigned f1 = 14,
  parameter int unsigned i2 = 2,
  parameter int unsigned f2 = 14,
  parameter int unsigned i3 = 2,
  parameter int unsigned f3 = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [i1+f1-1:0] in1,
  input  logic             i_sign1,
  input  logic [i2+f2-1:0] in2,
  input  logic             i_sign2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [i3+f3-1:0] out,
  output logic             o_sign,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned N1   = i1 + f1;
  localparam int unsigned N2   = i2 + f2;
  localparam int unsigned N3   = i3 + f3;
  // Two spare integer bits: one for unsigned-to-signed, one for the carry of the sum
  localparam int unsigned FI   = ((i1 > i2) ? i1 : i2) + 2;
  localparam int unsigned FF12 = (f1 > f2) ? f1 : f2;
  localparam int unsigned FF   = (FF12 > f3) ? FF12 : f3;
  localparam int unsigned W    = FI + FF;
  // Compare width must hold both the internal sum and the unsigned output maximum
  localparam int unsigned CW   = ((W > N3 + 1) ? W : N3 + 1) + 1;

  localparam logic signed [CW-1:0] One  = CW'(1);
  localparam logic signed [CW-1:0] SMax = (One <<< (N3 - 1)) - One;
  localparam logic signed [CW-1:0] SMin = -(One <<< (N3 - 1));
  localparam logic signed [CW-1:0] UMax = (One <<< N3) - One;
  localparam logic signed [CW-1:0] UMin = '0;

  logic                s1_valid_q, s2_valid_q;
  logic signed [W-1:0] s1_a_q, s1_b_q;
  logic                s1_sign_q, s2_sign_q;
  logic signed [W-1:0] s2_sum_q;

  logic                s1_adv, s2_adv, s3_adv;
  logic                fill1, fill2;
  logic signed [W-1:0] a_al, b_al;
  logic signed [W-1:0] sh;
  logic signed [CW-1:0] ext, hi, lo;
  logic                ovf, unf;
  logic [N3-1:0]       res;

  // Backpressure chain: each stage moves when its successor is empty or moving
  always_comb begin
    s3_adv   = !out_valid || out_ready;
    s2_adv   = !s2_valid_q || s3_adv;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Align: extend by operand signedness, then shift fraction up to FF bits
  always_comb begin
    fill1 = i_sign1 & in1[N1-1];
    fill2 = i_sign2 & in2[N2-1];
    a_al  = $signed({{(W-N1){fill1}}, in1}) <<< (FF - f1);
    b_al  = $signed({{(W-N2){fill2}}, in2}) <<< (FF - f2);
  end

  // Stage 1 register: aligned operands and result signedness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sign_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= a_al;
        s1_b_q    <= b_al;
        s1_sign_q <= i_sign1 | i_sign2;
      end
    end
  end

  // Stage 2 register: exact sum in the internal width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_sign_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q  <= s1_a_q + s1_b_q;
        s2_sign_q <= s1_sign_q;
      end
    end
  end

  // Convert: floor to f3 fraction bits, range-check, wrap or saturate
  always_comb begin
    sh  = s2_sum_q >>> (FF - f3);
    ext = {{(CW-W){sh[W-1]}}, sh};
    hi  = s2_sign_q ? SMax : UMax;
    lo  = s2_sign_q ? SMin : UMin;
    ovf = ext > hi;
    unf = ext < lo;
    res = ext[N3-1:0];
`ifdef FP_ADD_SAT_EN
    if (ovf) begin
      res = hi[N3-1:0];
    end else if (unf) begin
      res = lo[N3-1:0];
    end
`endif
  end

  // Stage 3 register: outputs, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      o_sign    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (s3_adv) begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        out       <= res;
        o_sign    <= s2_sign_q;
        overflow  <= ovf;
        underflow <= unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: scoreboard on the default Q2.14 instance plus directed and
// random checks of a format-converting instance (f2=8, i3=6, f3=4).
module tb_fp_add_pipe;

  typedef struct {
    logic [15:0] out;
    bit          sg;
    bit          ov;
    bit          un;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in1 = '0, in2 = '0;
  logic        i_sign1 = 1'b0, i_sign2 = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out;
  logic        o_sign, overflow, underflow;

  logic        b_in_valid = 1'b0, b_in_ready;
  logic [15:0] b_in1 = '0;
  logic [9:0]  b_in2 = '0;
  logic        b_sign1 = 1'b0, b_sign2 = 1'b0;
  logic        b_out_valid;
  logic [9:0]  b_out;
  logic        b_o_sign, b_ovf, b_unf;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t scb[$];
  exp_t nok = '{out: 16'h0, sg: 1'b0, ov: 1'b0, un: 1'b0, cyc: 0, lat: 1'b0};

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .i_sign1(i_sign1), .in2(in2), .i_sign2(i_sign2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .o_sign(o_sign),
    .overflow(overflow), .underflow(underflow)
  );

  fp_add_pipe #(.i1(2), .f1(14), .i2(2), .f2(8), .i3(6), .f3(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in1(b_in1), .i_sign1(b_sign1), .in2(b_in2), .i_sign2(b_sign2),
    .out_valid(b_out_valid), .out_ready(1'b1), .out(b_out), .o_sign(b_o_sign),
    .overflow(b_ovf), .underflow(b_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: real values scaled to a common fraction, floor division, range test
  function automatic void ref_add(input int ia, fa, ib, fb, io, fo, input bit sa, sbit,
                                  input longint a, b, output longint o, output bit ov,
                                  output bit un);
    int     fm, n;
    longint va, vb, s, lo, hi;
    fm = fa;
    if (fb > fm) fm = fb;
    if (fo > fm) fm = fo;
    n  = io + fo;
    va = a;
    vb = b;
    if (sa && a[ia+fa-1]) va = a - (64'sd1 <<< (ia + fa));
    if (sbit && b[ib+fb-1]) vb = b - (64'sd1 <<< (ib + fb));
    s = (va <<< (fm - fa)) + (vb <<< (fm - fb));
    s = s >>> (fm - fo);
    if (sa || sbit) begin
      lo = -(64'sd1 <<< (n - 1));
      hi = (64'sd1 <<< (n - 1)) - 1;
    end else begin
      lo = 0;
      hi = (64'sd1 <<< n) - 1;
    end
    ov = s > hi;
    un = s < lo;
`ifdef FP_ADD_SAT_EN
    if (ov) s = hi;
    else if (un) s = lo;
`endif
    o = s & ((64'sd1 <<< n) - 1);
  endfunction

  // One cycle of stimulus on the default instance; records expectation on transfer
  task automatic drive(input bit v, input logic [15:0] a, input bit sa, input logic [15:0] b,
                       input bit sbit, input bit ordy, input bit use_k, input exp_t k,
                       output bit acc);
    exp_t   e;
    longint o;
    bit     ov, un;
    @(negedge clk);
    in_valid = v; in1 = a; i_sign1 = sa; in2 = b; i_sign2 = sbit; out_ready = ordy;
    #2;
    acc = v && in_ready;
    if (acc) begin
      if (use_k) begin
        e = k;
      end else begin
        ref_add(2, 14, 2, 14, 2, 14, sa, sbit, longint'(a), longint'(b), o, ov, un);
        e.out = o[15:0]; e.sg = sa | sbit; e.ov = ov; e.un = un; e.lat = 1'b0;
      end
      e.cyc = cyc;
      scb.push_back(e);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && scb.size() != 0; i++) drive(0, 16'h0, 0, 16'h0, 0, 1, 0, nok, acc);
    drive(0, 16'h0, 0, 16'h0, 0, 1, 0, nok, acc);
    chk("drain_empty", scb.size(), 0);
  endtask

  // Monitor: pops and compares on every output transfer; checks hold during stalls
  initial begin
    bit          hold = 1'b0;
    logic [15:0] h_out;
    logic [2:0]  h_fl;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_out", out, h_out);
          chk("stall_flags", {o_sign, overflow, underflow}, h_fl);
        end
        if (out_valid && out_ready) begin
          if (scb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got 0x%0h with no result outstanding", out);
          end else begin
            e = scb.pop_front();
            chk("out", out, e.out);
            chk("o_sign", o_sign, e.sg);
            chk("overflow", overflow, e.ov);
            chk("underflow", underflow, e.un);
            if (e.lat) chk("latency", cyc - e.cyc, 3);
          end
        end
        hold  = out_valid && !out_ready;
        h_out = out;
        h_fl  = {o_sign, overflow, underflow};
      end
    end
  end

  task automatic check_b(input logic [15:0] a, input bit sa, input logic [9:0] b, input bit sbit,
                         input longint kout);
    longint o;
    bit     ov, un, got;
    ref_add(2, 14, 2, 8, 6, 4, sa, sbit, longint'(a), longint'(b), o, ov, un);
    if (kout >= 0) o = kout;
    @(negedge clk);
    b_in_valid = 1; b_in1 = a; b_sign1 = sa; b_in2 = b; b_sign2 = sbit;
    #2;
    chk("b_in_ready", b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        #2;
        if (b_out_valid) got = 1;
        else @(negedge clk);
      end
    end
    chk("b_timeout", got, 1);
    if (got) begin
      chk("b_out", b_out, o);
      chk("b_o_sign", b_o_sign, sa | sbit);
      chk("b_flags", {b_ovf, b_unf}, {ov, un});
    end
  endtask

  initial begin
    bit   acc;
    int   n_acc, idx, seen;
    exp_t k;
    logic [15:0] bp_a[6] = '{16'h0100, 16'h1234, 16'h7FFF, 16'h8001, 16'h4000, 16'hFFFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {o_sign, overflow, underflow}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);

    // Directed values with known results and exact 3-cycle latency
    k = '{out: 16'hE000, sg: 0, ov: 0, un: 0, cyc: 0, lat: 1};
    drive(1, 16'h6000, 0, 16'h8000, 0, 1, 1, k, acc); drain();
    k = '{out: 16'hE000, sg: 1, ov: 0, un: 0, cyc: 0, lat: 1};
    drive(1, 16'hC000, 1, 16'h2000, 0, 1, 1, k, acc); drain();
`ifdef FP_ADD_SAT_EN
    k = '{out: 16'hFFFF, sg: 0, ov: 1, un: 0, cyc: 0, lat: 1};
`else
    k = '{out: 16'h4000, sg: 0, ov: 1, un: 0, cyc: 0, lat: 1};
`endif
    drive(1, 16'hC000, 0, 16'h8000, 0, 1, 1, k, acc); drain();
`ifdef FP_ADD_SAT_EN
    k = '{out: 16'h8000, sg: 1, ov: 0, un: 1, cyc: 0, lat: 1};
`else
    k = '{out: 16'h4000, sg: 1, ov: 0, un: 1, cyc: 0, lat: 1};
`endif
    drive(1, 16'h8000, 1, 16'hC000, 1, 1, 1, k, acc); drain();

    // Format-converting instance
    check_b(16'h0001, 0, 10'h100, 0, 64'h010);
    check_b(16'hFFFF, 1, 10'h000, 0, 64'h3FF);
    for (int i = 0; i < 20; i++)
      check_b(16'($urandom), 1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)), -1);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 0, nok, acc);
    drain();

    // Six back-to-back pairs with the consumer stalled for five cycles
    n_acc = 0;
    idx   = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      drive(1, bp_a[idx], 0, 16'h0800, 1, c >= 5, 0, nok, acc);
      if (acc) idx++;
      if (c < 5 && acc) n_acc++;
      if (c == 4) begin
        chk("bp_accepted", n_acc, 3);
        chk("bp_in_ready", in_ready, 0);
      end
    end
    chk("bp_all_sent", idx, 6);
    drain();

    // Asynchronous reset with two results in flight
    drive(1, 16'h1111, 0, 16'h2222, 0, 0, 0, nok, acc);
    drive(1, 16'h3333, 0, 16'h0444, 0, 0, 0, nok, acc);
    drive(0, 16'h0, 0, 16'h0, 0, 0, 0, nok, acc);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out", out, 0);
    chk("flush_flags", {o_sign, overflow, underflow}, 0);
    scb.delete();
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 16'h0, 0, 16'h0, 0, 1, 0, nok, acc);
      if (out_valid) seen++;
    end
    chk("flush_nothing_after", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
